// File: rtl/bin_a_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one operand bit per clock.
// Optional macro LEADING_ZERO_BLANK_EN adds the registered digit_en blanking output.
module bin_a_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
`ifdef LEADING_ZERO_BLANK_EN
    ,
    output logic [DIGITS-1:0]     digit_en
`endif
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    generate
        if (WIDTH < 1 || DIGITS < 1) begin : g_bad_params
            $error("bin_a_bcd_seq: WIDTH and DIGITS must both be >= 1");
        end
    endgenerate

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   dig_q, dig_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            oacc_q, oacc_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;
    logic [BW-1:0]   adj;
    logic [BW-1:0]   dig_sh;
    logic [WIDTH-1:0] opd_sh;
    logic            carry;

    // All digits are corrected in parallel from their pre-shift values.
    function automatic logic [BW-1:0] add3(input logic [BW-1:0] d);
        logic [BW-1:0] r;
        r = d;
        for (int k = 0; k < DIGITS; k++) begin
            if (d[4*k +: 4] >= 4'd5) r[4*k +: 4] = d[4*k +: 4] + 4'd3;
        end
        return r;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] en_q, en_d;

    function automatic logic [DIGITS-1:0] lead_en(input logic [BW-1:0] d, input logic ovf);
        logic [DIGITS-1:0] r;
        logic              seen;
        seen = 1'b0;
        r    = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            seen = seen | (d[4*k +: 4] != 4'd0);
            r[k] = seen | ovf | (k == 0);
        end
        return r;
    endfunction
`endif

    always_comb begin
        adj                    = add3(dig_q);
        {carry, dig_sh, opd_sh} = {adj, opd_q, 1'b0};
    end

    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        opd_d   = opd_q;
        cnt_d   = cnt_q;
        oacc_d  = oacc_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        en_d    = en_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    opd_d   = bin;
                    dig_d   = '0;
                    oacc_d  = 1'b0;
                    cnt_d   = CW'(WIDTH);
                end
            end
            SHIFT: begin
                dig_d  = dig_sh;
                opd_d  = opd_sh;
                cnt_d  = cnt_q - 1'b1;
                oacc_d = oacc_q | carry;
                // Last shift: publish the result on this same edge.
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    bcd_d   = dig_sh;
                    ovf_d   = oacc_q | carry;
                    done_d  = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
                    en_d    = lead_en(dig_sh, oacc_q | carry);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dig_q   <= '0;
            opd_q   <= '0;
            cnt_q   <= '0;
            oacc_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            en_q    <= DIGITS'(1);
`endif
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            opd_q   <= opd_d;
            cnt_q   <= cnt_d;
            oacc_q  <= oacc_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
`ifdef LEADING_ZERO_BLANK_EN
            en_q    <= en_d;
`endif
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = ovf_q;
`ifdef LEADING_ZERO_BLANK_EN
    assign digit_en = en_q;
`endif

endmodule

// File: doc/bin_a_bcd_seq.md
Name: bin_a_bcd_seq

Overview:
Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double dabble) method, one input bit per clock.
- Generalises the single hundreds-digit extractor to arbitrary operand width and any digit count.
- Adds a start/busy/done handshake and an overflow flag.
- Feeds the 7-segment display path; one conversion yields all BCD digits (units, tens, hundreds, ...).

Parameters:
WIDTH, 8, binary operand width in bits (>=1)
DIGITS, 3, number of BCD output digits (>=1); digit 0 = units

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request conversion of bin; sampled only in IDLE
bin  input  WIDTH  binary operand, captured on the accepting edge
busy  output  1  high while a conversion is in progress
done  output  1  single-cycle pulse: bcd/overflow valid and updated
bcd  output  4*DIGITS  result; bits [4k+3:4k] = digit k, held until next done
overflow  output  1  operand >= 10^DIGITS; held with bcd
digit_en  output  DIGITS  only with LEADING_ZERO_BLANK_EN; see Optional Feature

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy=0, done=0, overflow=0; bcd=0; internal shift register and bit counter cleared.
  - Any conversion in flight is abandoned; no done pulse follows.
- FSM states: IDLE, SHIFT.
  - IDLE -> SHIFT on start=1: capture bin into shift register; clear BCD accumulator and overflow accumulator; counter=WIDTH; busy=1 from next cycle.
  - SHIFT, each edge:
    - every BCD digit >=5 gets +3 (all digits evaluated in parallel on pre-shift values);
    - then {digits, operand} shifts left by 1; counter decrements.
    - A 1 shifted out of the top digit sets the overflow accumulator (sticky for this conversion).
  - SHIFT -> IDLE on the edge where the counter reaches 0 (the WIDTH-th shift edge): on that same edge, bcd <= final digits, overflow <= accumulator, done=1, busy=0.
- Latency: start accepted at edge E; done high during the cycle after edge E+WIDTH. Throughput: one conversion per WIDTH+1 cycles (back-to-back start allowed in the done cycle).
- done: exactly one cycle per completed conversion; deasserts next edge unconditionally.
- start while busy=1: ignored; bin changes while busy have no effect.
- Overflow result: bcd = operand mod 10^DIGITS; overflow=1.
- bcd/overflow change only on done edges (or reset); stable otherwise.
- Width rules:
  - Adjust is 4-bit: digit+3 never exceeds 4'd12 pre-shift.
  - Internal register is 4*DIGITS+WIDTH bits plus one overflow bit.
- Elaboration error if WIDTH<1 or DIGITS<1.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - Adds output digit_en[DIGITS-1:0], registered and updated on the done edge with bcd; reset value 1 in bit 0, 0 elsewhere.
  - digit_en[k]=1 if digit k or any higher digit is non-zero; digit_en[0] is always 1 (zero displays as "0").
  - When overflow=1, all bits are 1.
- Undefined: port and logic absent; display shows all digits including leading zeros.

Test Plan:
- Default params: reset, start with bin=8'd255 -> busy high for 8 cycles, done pulse at edge E+8, bcd=12'h255, overflow=0.
- bin=8'd0, then 8'd100, then 8'd99 back-to-back (start asserted in each done cycle) -> bcd 12'h000, 12'h100, 12'h099, each done exactly 9 cycles apart.
- start pulsed again mid-conversion with bin=8'd7 (first operand 8'd42) -> ignored; result 12'h042, single done.
- DIGITS=2, bin=8'd150 -> bcd=8'h50, overflow=1. Then bin=8'd99 -> bcd=8'h99, overflow=0.
- rst asserted at cycle 4 of a conversion of 8'd200 -> outputs 0 immediately (async), no done. Fresh start with 8'd200 -> bcd=12'h200.
- With LEADING_ZERO_BLANK_EN: bin 8'd7 -> digit_en=3'b001; 8'd0 -> 3'b001; 8'd105 -> 3'b111; 8'd40 -> 3'b011.
